n_mux: RTL and testbench

- Parameterised N-way, W-bit data multiplexer with a registered output. The default configuration is 5 inputs of 8 bits, selected by a 3-bit index.
- Sits in the datapath wherever one of several equal-width vectors is forwarded downstream.
- Output and error flag are registered: one cycle of latency, with a synchronous reset.

---
 rtl/n_mux.sv | 102 ++++++++++
 tb/tb_n_mux.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/n_mux.sv
// ---------------------------------------------------------------------------
// n_mux : N-way, W-bit data multiplexer with registered output.
//
// One of the io_Dvect_k inputs is selected by io_sel and registered into
// io_Ovect, so the output lags the inputs by exactly one clock. If io_sel
// selects an input that does not exist, io_sel_err is set for that cycle.
//
// Optional feature (compile-time macro NMUX_HOLD_ON_ERR_EN):
//   defined   - an out-of-range select keeps the previous io_Ovect value.
//   undefined - an out-of-range select loads zero into io_Ovect.
// In both builds reset clears io_Ovect and io_sel_err to zero.
//
// Parameters:
//   NUM_INPUTS - number of used data inputs. The port list has five inputs,
//                so the valid range is 2..5. Inputs at or above NUM_INPUTS
//                are ignored, and selecting them counts as out of range.
//   DATA_W     - width of each data input and of io_Ovect.
//   SEL_W      - width of io_sel; 2**SEL_W must be >= NUM_INPUTS.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   io_Dvect_0-4 in   DATA_W data inputs
//   io_sel       in   SEL_W unsigned select index
//   io_Ovect     out  DATA_W registered selected data
//   io_sel_err   out  registered out-of-range select flag
// ---------------------------------------------------------------------------
module n_mux #(
    parameter int NUM_INPUTS = 5,
    parameter int DATA_W     = 8,
    parameter int SEL_W      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] io_Dvect_0,
    input  logic [DATA_W-1:0] io_Dvect_1,
    input  logic [DATA_W-1:0] io_Dvect_2,
    input  logic [DATA_W-1:0] io_Dvect_3,
    input  logic [DATA_W-1:0] io_Dvect_4,
    input  logic [SEL_W-1:0]  io_sel,
    output logic [DATA_W-1:0] io_Ovect,
    output logic              io_sel_err
);

    localparam int PORT_CNT = 5;

    logic [DATA_W-1:0] dvect [PORT_CNT];
    logic [DATA_W-1:0] pick;
    logic              sel_ok;
    logic [DATA_W-1:0] ovect_d, ovect_q;
    logic              sel_err_d, sel_err_q;

    assign dvect[0] = io_Dvect_0;
    assign dvect[1] = io_Dvect_1;
    assign dvect[2] = io_Dvect_2;
    assign dvect[3] = io_Dvect_3;
    assign dvect[4] = io_Dvect_4;

    // One extra bit on both sides so NUM_INPUTS == 2**SEL_W compares correctly.
    assign sel_ok = ({1'b0, io_sel} < (SEL_W + 1)'(NUM_INPUTS));

    // Decode through a loop rather than an array index so that select values
    // beyond the populated inputs never address outside the array.
    always_comb begin
        pick = '0;
        for (int k = 0; k < PORT_CNT; k++) begin
            if (k < NUM_INPUTS && io_sel == SEL_W'(k)) begin
                pick = dvect[k];
            end
        end
    end

    always_comb begin
        ovect_d   = '0;
        sel_err_d = 1'b0;
        if (sel_ok) begin
            ovect_d = pick;
        end else begin
            sel_err_d = 1'b1;
`ifdef NMUX_HOLD_ON_ERR_EN
            ovect_d = ovect_q;
`else
            ovect_d = '0;
`endif
        end
    end

    // Output register stage
    always_ff @(posedge clk) begin
        if (reset) begin
            ovect_q   <= '0;
            sel_err_q <= 1'b0;
        end else begin
            ovect_q   <= ovect_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign io_Ovect   = ovect_q;
    assign io_sel_err = sel_err_q;

endmodule

// File: tb/tb_n_mux.sv
module tb_n_mux;

    localparam int N  = 5;
    localparam int DW = 8;
    localparam int SW = 3;
`ifdef NMUX_HOLD_ON_ERR_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] d [N];
    logic [SW-1:0] sel = '0;
    logic [DW-1:0] ovect;
    logic          sel_err;

    int checks   = 0;
    int failures = 0;

    // Reference state: what the output register should currently hold.
    logic [DW-1:0] exp_o   = '0;
    logic          exp_err = 1'b0;

    always #5 clk = ~clk;

    n_mux #(.NUM_INPUTS(N), .DATA_W(DW), .SEL_W(SW)) dut (
        .clk        (clk),
        .reset      (reset),
        .io_Dvect_0 (d[0]),
        .io_Dvect_1 (d[1]),
        .io_Dvect_2 (d[2]),
        .io_Dvect_3 (d[3]),
        .io_Dvect_4 (d[4]),
        .io_sel     (sel),
        .io_Ovect   (ovect),
        .io_sel_err (sel_err)
    );

    // Model one edge from the inputs as they stand now, then advance the
    // clock and settle 1 time unit past the edge.
    task automatic tick();
        int s;
        s = int'(sel);
        if (reset) begin
            exp_o   = '0;
            exp_err = 1'b0;
        end else if (s < N) begin
            exp_o   = d[s];
            exp_err = 1'b0;
        end else begin
            exp_o   = HOLD ? exp_o : '0;
            exp_err = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        d[0] = 8'hA5; d[1] = 8'h01; d[2] = 8'h02; d[3] = 8'h03; d[4] = 8'h04;
        sel = 3'd0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (ovect !== 8'h00 || sel_err !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got o=%h err=%b want o=00 err=0", i, ovect, sel_err);
            end
        end
        reset = 1'b0;
        tick();
        checks++;
        if (ovect !== 8'hA5 || sel_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got o=%h err=%b want o=a5 err=0", ovect, sel_err);
        end
    endtask

    task automatic test_sweep();
        logic [DW-1:0] want;
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44; d[4] = 8'h55;
        for (int s = 0; s < N; s++) begin
            sel = SW'(s);
            tick();
            want = DW'(8'h11 * (s + 1));
            checks++;
            if (ovect !== want || sel_err !== 1'b0) begin
                failures++;
                $display("FAIL sweep sel=%0d got o=%h err=%b want o=%h err=0", s, ovect, sel_err, want);
            end
        end
    endtask

    task automatic test_data_tracking();
        logic [DW-1:0] vals [3];
        vals[0] = 8'h00; vals[1] = 8'hFF; vals[2] = 8'h7E;
        sel = 3'd2;
        for (int i = 0; i < 3; i++) begin
            d[2] = vals[i];
            tick();
            checks++;
            if (ovect !== vals[i]) begin
                failures++;
                $display("FAIL track step=%0d got o=%h want o=%h", i, ovect, vals[i]);
            end
            // Disturb the other inputs; the output must not move.
            d[0] = 8'($urandom); d[1] = 8'($urandom); d[3] = 8'($urandom); d[4] = 8'($urandom);
            tick();
            checks++;
            if (ovect !== vals[i]) begin
                failures++;
                $display("FAIL track_other step=%0d got o=%h want o=%h", i, ovect, vals[i]);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [SW-1:0] sels [3];
        logic [DW-1:0] want_o [3];
        logic          want_e [3];
        sels[0] = 3'd5; sels[1] = 3'd7; sels[2] = 3'd3;
        want_o[0] = HOLD ? 8'h55 : 8'h00;
        want_o[1] = HOLD ? 8'h55 : 8'h00;
        want_o[2] = 8'h44;
        want_e[0] = 1'b1; want_e[1] = 1'b1; want_e[2] = 1'b0;
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44; d[4] = 8'h55;
        sel = 3'd4;
        tick();
        checks++;
        if (ovect !== 8'h55) begin
            failures++;
            $display("FAIL oor_setup got o=%h want o=55", ovect);
        end
        for (int i = 0; i < 3; i++) begin
            sel = sels[i];
            tick();
            checks++;
            if (ovect !== want_o[i] || sel_err !== want_e[i]) begin
                failures++;
                $display("FAIL oor sel=%0d got o=%h err=%b want o=%h err=%b",
                         sels[i], ovect, sel_err, want_o[i], want_e[i]);
            end
        end
    endtask

    task automatic test_midstream_reset();
        sel = 3'd4;
        d[4] = 8'hC3;
        tick();
        checks++;
        if (ovect !== 8'hC3) begin
            failures++;
            $display("FAIL mid_pre got o=%h want o=c3", ovect);
        end
        sel = 3'd6;
        tick();
        reset = 1'b1;
        sel = 3'd4;
        tick();
        checks++;
        if (ovect !== 8'h00 || sel_err !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got o=%h err=%b want o=00 err=0", ovect, sel_err);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (ovect !== 8'hC3 || sel_err !== 1'b0) begin
            failures++;
            $display("FAIL mid_after got o=%h err=%b want o=c3 err=0", ovect, sel_err);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < N; k++) d[k] = 8'($urandom);
            sel   = SW'($urandom_range(0, 7));
            reset = ($urandom_range(0, 19) == 0);
            tick();
            checks++;
            if (ovect !== exp_o || sel_err !== exp_err) begin
                failures++;
                $display("FAIL random i=%0d got o=%h err=%b want o=%h err=%b",
                         i, ovect, sel_err, exp_o, exp_err);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < N; k++) d[k] = '0;
        @(negedge clk);
        test_reset();
        test_sweep();
        test_data_tracking();
        test_out_of_range();
        test_midstream_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
